// File: rtl/vram_map_pkg.sv
// Foreground VRAM address map and scheduler state type, shared by the
// foreground/background decode logic and the write scheduler.
package vram_map_pkg;

  localparam logic [11:0] PMF_BASE = 12'h000;
  localparam int          PMF_SIZE = 512;
  localparam logic [11:0] OBM_BASE = 12'h800;
  localparam int          OBM_SIZE = 256;

  typedef enum logic {ACCUMULATE, DRAIN} sched_state_t;

  function automatic logic is_pmf(input logic [11:0] addr);
    logic [11:0] off;
    off = addr - PMF_BASE;
    return off < 12'(PMF_SIZE);
  endfunction

  function automatic logic is_obm(input logic [11:0] addr);
    logic [11:0] off;
    off = addr - OBM_BASE;
    return off < 12'(OBM_SIZE);
  endfunction

endpackage

// File: rtl/vram_write_scheduler_m_if.sv
// CPU-side VRAM write request channel (valid/ready handshake).
interface vram_write_scheduler_m_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_address;
  logic [7:0]        req_data;

  modport master (output req_valid, req_address, req_data, input req_ready);
  modport slave  (input req_valid, req_address, req_data, output req_ready);
endinterface

// File: rtl/sync_fifo_m.sv
// Single-clock FIFO with registered occupancy; head is read combinationally.
module sync_fifo_m #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop_ok)  rptr <= rptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/vram_write_scheduler_m.sv
// Buffers foreground VRAM writes during active display and commits them,
// one per cycle, only while current_y lies inside the drain window.
module vram_write_scheduler_m
  import vram_map_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int VRAM_ADDR_WIDTH = 12,
  parameter int DRAIN_START_Y   = 240,
  parameter int DRAIN_END_Y     = 520
) (
  input  logic                             gpu_clk,
  input  logic                             rst,
  input  logic [8:0]                       current_y,
  vram_write_scheduler_m_if.slave          req,
  output logic [VRAM_ADDR_WIDTH-1:0]       vram_address,
  output logic [7:0]                       data_out,
  output logic                             write_enable,
  output logic                             SELECT_pmf,
  output logic                             SELECT_obm,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic                             dropped,
  output logic                             frame_done
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = VRAM_ADDR_WIDTH + 8;

  sched_state_t               state, state_nxt;
  logic                       in_window, xfer, in_map, push, drop, pop;
  logic                       fifo_full, fifo_empty, empty_after, frame_done_nxt;
  logic [ENT_W-1:0]           head;
  logic [VRAM_ADDR_WIDTH-1:0] head_addr;
  logic [7:0]                 head_data;
  logic [LVL_W-1:0]           count;
  logic [31:0]                y_ext;

  // Wide compare so a window end beyond 511 simply means "until y wraps".
  assign y_ext     = 32'(current_y);
  assign in_window = (y_ext >= 32'(DRAIN_START_Y)) && (y_ext < 32'(DRAIN_END_Y));

  assign req.req_ready = !fifo_full;
  assign xfer   = req.req_valid && req.req_ready;
  assign in_map = is_pmf(12'(req.req_address)) || is_obm(12'(req.req_address));
  assign push   = xfer && in_map;
  assign drop   = xfer && !in_map;

  assign head_addr   = head[ENT_W-1:8];
  assign head_data   = head[7:0];
  assign fifo_level  = count;
  assign empty_after = (count == LVL_W'(pop)) && !push;

  sync_fifo_m #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (gpu_clk),
    .rst   (rst),
    .push  (push),
    .wdata ({req.req_address, req.req_data}),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge gpu_clk) begin
    if (rst) state <= ACCUMULATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pop            = 1'b0;
    frame_done_nxt = 1'b0;
    case (state)
      ACCUMULATE: begin
        if (in_window) state_nxt = DRAIN;
      end
      DRAIN: begin
        pop = !fifo_empty;
        if (!in_window) begin
          state_nxt      = ACCUMULATE;
          frame_done_nxt = empty_after;
        end
      end
      default: state_nxt = ACCUMULATE;
    endcase
  end

  // Commit stage: the popped head is registered onto the foreground port.
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      write_enable <= 1'b0;
      SELECT_pmf   <= 1'b0;
      SELECT_obm   <= 1'b0;
      vram_address <= '0;
      data_out     <= '0;
      dropped      <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      write_enable <= pop;
      SELECT_pmf   <= pop && is_pmf(12'(head_addr));
      SELECT_obm   <= pop && is_obm(12'(head_addr));
      if (pop) begin
        vram_address <= head_addr;
        data_out     <= head_data;
      end
      dropped    <= dropped | drop;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler_m.sv
// Randomised and directed bench for vram_write_scheduler_m against a
// queue-based behavioural model of the deferred write scheduler.
module tb_vram_write_scheduler_m;
  localparam int DEPTH   = 16;
  localparam int Y_START = 240;
  localparam int Y_END   = 500;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  cur_y;
  logic [11:0] vram_address;
  logic [7:0]  data_out;
  logic        write_enable, sel_pmf, sel_obm, dropped, frame_done;
  logic [4:0]  fifo_level;

  vram_write_scheduler_m_if #(.ADDR_W(12)) bus ();

  vram_write_scheduler_m #(
    .FIFO_DEPTH      (DEPTH),
    .VRAM_ADDR_WIDTH (12),
    .DRAIN_START_Y   (Y_START),
    .DRAIN_END_Y     (Y_END)
  ) dut (
    .gpu_clk      (clk),
    .rst          (rst),
    .current_y    (cur_y),
    .req          (bus.slave),
    .vram_address (vram_address),
    .data_out     (data_out),
    .write_enable (write_enable),
    .SELECT_pmf   (sel_pmf),
    .SELECT_obm   (sel_obm),
    .fifo_level   (fifo_level),
    .dropped      (dropped),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue; committing is allowed in a cycle iff
  // y was inside the window on the previous edge.
  bit [19:0]   q[$];
  bit          mvalid = 0;
  bit          m_drain;
  bit          e_we, e_pmf, e_obm, e_dropped, e_fd, e_ready;
  bit [11:0]   e_addr;
  bit [7:0]    e_data;
  int          e_level;
  int          acc_cnt = 0;
  bit          m_win, m_pop, m_xfer, m_inmap;
  bit [19:0]   m_head;

  function automatic bit in_map(input logic [11:0] a);
    return (a < 12'h200) || (a >= 12'h800 && a < 12'h900);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_drain = 0; e_we = 0; e_pmf = 0; e_obm = 0; e_addr = 0; e_data = 0;
      e_dropped = 0; e_fd = 0; mvalid = 1;
    end else if (mvalid) begin
      m_win   = (int'(cur_y) >= Y_START) && (int'(cur_y) < Y_END);
      m_pop   = m_drain && (q.size() > 0);
      m_xfer  = bus.req_valid && (q.size() != DEPTH);
      m_inmap = in_map(bus.req_address);
      e_we = m_pop; e_pmf = 0; e_obm = 0;
      if (m_pop) begin
        m_head = q.pop_front();
        e_addr = m_head[19:8];
        e_data = m_head[7:0];
        e_pmf  = (m_head[19:8] < 12'h200);
        e_obm  = (m_head[19:8] >= 12'h800);
      end
      if (m_xfer) acc_cnt++;
      if (m_xfer && m_inmap) q.push_back({bus.req_address, bus.req_data});
      if (m_xfer && !m_inmap) e_dropped = 1;
      e_fd    = m_drain && !m_win && (q.size() == 0);
      m_drain = m_win;
    end
    e_level = q.size();
    e_ready = (q.size() != DEPTH);
  end

  // Observed commits, for the directed literal checks.
  bit [21:0] obs[$];
  int        fd_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (mvalid) begin
      chk("write_enable", 32'(write_enable), 32'(e_we));
      chk("SELECT_pmf",   32'(sel_pmf),      32'(e_pmf));
      chk("SELECT_obm",   32'(sel_obm),      32'(e_obm));
      chk("vram_address", 32'(vram_address), 32'(e_addr));
      chk("data_out",     32'(data_out),     32'(e_data));
      chk("fifo_level",   32'(fifo_level),   32'(e_level));
      chk("dropped",      32'(dropped),      32'(e_dropped));
      chk("frame_done",   32'(frame_done),   32'(e_fd));
      chk("req_ready",    32'(bus.req_ready), 32'(e_ready));
      if (write_enable === 1'b1) obs.push_back({sel_pmf, sel_obm, vram_address, data_out});
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_address = a; bus.req_data = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic set_y(input int y);
    @(negedge clk);
    cur_y = 9'(y);
  endtask

  task automatic wait_obs(input int n);
    int t;
    t = 0;
    while (obs.size() < n && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (obs.size() < n) chk("wait_obs_timeout", 32'(obs.size()), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, a0, t;
    logic [11:0] a;
    int ylist[9] = '{0, 100, 239, 240, 241, 300, 499, 500, 511};

    rst = 1'b1; cur_y = 9'd100;
    bus.req_valid = 1'b0; bus.req_address = '0; bus.req_data = '0;
    cycles(3);
    rst = 1'b0;
    cycles(1);
    chk("reset_level", 32'(fifo_level), 0);
    chk("reset_ready", 32'(bus.req_ready), 1);
    chk("reset_we",    32'(write_enable), 0);

    // Single OBM write deferred until the window opens
    obs.delete(); fd_cnt = 0;
    push(12'h805, 8'h3C);
    cycles(5);
    chk("s1_no_early_commit", 32'(obs.size()), 0);
    set_y(240);
    cycles(4);
    chk("s1_commit_count", 32'(obs.size()), 1);
    if (obs.size() >= 1) chk("s1_commit", 32'(obs[0]), 32'({2'b01, 12'h805, 8'h3C}));
    set_y(499); cycles(3);
    chk("s1_no_fd_in_window", 32'(fd_cnt), 0);
    set_y(500); cycles(3);
    chk("s1_frame_done", 32'(fd_cnt), 1);
    set_y(10);

    // Fill to full, 17th held with valid until space opens
    obs.delete();
    for (int i = 0; i < 16; i++) begin
      a = (i % 2 == 1) ? 12'(12'h800 + i) : 12'(i * 3);
      push(a, 8'(i));
    end
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_address = 12'h8A0; bus.req_data = 8'd16;
    cycles(3);
    chk("s2_full_level", 32'(fifo_level), 16);
    chk("s2_full_ready", 32'(bus.req_ready), 0);
    a0 = acc_cnt;
    cur_y = 9'd240;
    t = 0;
    while (acc_cnt == a0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("s2_17th_accepted", 32'(acc_cnt - a0), 1);
    bus.req_valid = 1'b0;
    cycles(25);
    chk("s2_commit_count", 32'(obs.size()), 17);
    for (int i = 0; i < 17 && i < obs.size(); i++) chk("s2_order", 32'(obs[i][7:0]), 32'(i));
    set_y(10);

    // Out-of-map requests are accepted and discarded
    obs.delete();
    push(12'h400, 8'hAA);
    cycles(1);
    chk("s3_dropped", 32'(dropped), 1);
    chk("s3_level", 32'(fifo_level), 0);
    push(12'h900, 8'h11);
    push(12'h200, 8'h12);
    push(12'h7FF, 8'h13);
    set_y(240); cycles(6);
    chk("s3_no_commit", 32'(obs.size()), 0);
    set_y(10);

    // Region boundaries
    obs.delete();
    push(12'h1FF, 8'h01);
    push(12'h000, 8'h02);
    push(12'h8FF, 8'h03);
    push(12'h800, 8'h04);
    set_y(240); cycles(8);
    chk("s4_count", 32'(obs.size()), 4);
    if (obs.size() == 4) begin
      chk("s4_1ff", 32'(obs[0]), 32'({2'b10, 12'h1FF, 8'h01}));
      chk("s4_000", 32'(obs[1]), 32'({2'b10, 12'h000, 8'h02}));
      chk("s4_8ff", 32'(obs[2]), 32'({2'b01, 12'h8FF, 8'h03}));
      chk("s4_800", 32'(obs[3]), 32'({2'b01, 12'h800, 8'h04}));
    end
    set_y(10);

    // Window closes mid-drain; remainder commits next frame
    obs.delete(); cycles(2); fd_cnt = 0;
    for (int i = 0; i < 8; i++) push(12'(12'h010 + i), 8'(8'h50 + i));
    set_y(240);
    wait_obs(2);
    cur_y = 9'd500;
    cycles(5);
    chk("s5_partial", 32'(obs.size()), 3);
    chk("s5_no_fd", 32'(fd_cnt), 0);
    chk("s5_level", 32'(fifo_level), 5);
    set_y(10); cycles(3);
    set_y(240); cycles(10);
    chk("s5_total", 32'(obs.size()), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++) chk("s5_order", 32'(obs[i][7:0]), 32'(8'h50 + i));
    set_y(500); cycles(3);
    chk("s5_fd_empty", 32'(fd_cnt), 1);
    set_y(10);

    // Randomised traffic with y jumping around the window edges
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      bus.req_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: bus.req_address = 12'($urandom_range(0, 12'h1FF));
        4, 5, 6, 7: bus.req_address = 12'(12'h800 | $urandom_range(0, 255));
        default:    bus.req_address = 12'($urandom);
      endcase
      bus.req_data = 8'($urandom);
      if ($urandom_range(0, 11) == 0) cur_y = 9'(ylist[$urandom_range(0, 8)]);
    end
    @(negedge clk);
    bus.req_valid = 1'b0; cur_y = 9'd10;
    cycles(3);

    // Reset in the middle of a drain
    for (int i = 0; i < 10; i++) push(12'(12'h100 + i), 8'(i));
    obs.delete();
    set_y(240);
    wait_obs(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s7_level", 32'(fifo_level), 0);
    chk("s7_dropped", 32'(dropped), 0);
    chk("s7_ready", 32'(bus.req_ready), 1);
    chk("s7_we", 32'(write_enable), 0);
    n0 = obs.size();
    set_y(10); cycles(3);
    set_y(240); cycles(20);
    chk("s7_no_writes", 32'(obs.size()), 32'(n0));
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
